// File: rtl/commit_trace_serializer.sv
// commit_trace_serializer: dual-retire commit trace FIFO, two records in and one record out per cycle.
module commit_trace_serializer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     c0_valid_i,
    input  logic [XLEN-1:0]          c0_pc_i,
    input  logic [XLEN-1:0]          c0_instr_i,
    input  logic [4:0]               c0_rd_i,
    input  logic [XLEN-1:0]          c0_rd_data_i,
    input  logic                     c0_mem_wrt_i,
    input  logic [XLEN-1:0]          c0_mem_addr_i,
    input  logic [XLEN-1:0]          c0_mem_data_i,
    input  logic                     c1_valid_i,
    input  logic [XLEN-1:0]          c1_pc_i,
    input  logic [XLEN-1:0]          c1_instr_i,
    input  logic [4:0]               c1_rd_i,
    input  logic [XLEN-1:0]          c1_rd_data_i,
    input  logic                     c1_mem_wrt_i,
    input  logic [XLEN-1:0]          c1_mem_addr_i,
    input  logic [XLEN-1:0]          c1_mem_data_i,
    output logic                     in_ready_o,
    input  logic                     trace_ready_i,
    output logic                     update_o,
    output logic [XLEN-1:0]          pc_o,
    output logic [XLEN-1:0]          instr_o,
    output logic [4:0]               reg_addr_o,
    output logic [XLEN-1:0]          reg_data_o,
    output logic                     mem_wrt_o,
    output logic [XLEN-1:0]          mem_addr_o,
    output logic [XLEN-1:0]          mem_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [31:0]              retired_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd_data;
        logic            mem_wrt;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
    } rec_t;
    rec_t fifo [DEPTH];
    rec_t rec0, rec1, head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [1:0] n_push;
    logic pop;
    // Fields that carry no meaning are zeroed on the way in so the output side never masks.
    assign rec0 = '{pc: c0_pc_i, instr: c0_instr_i, rd: c0_rd_i,
                    rd_data: c0_rd_i != 5'd0 ? c0_rd_data_i : '0, mem_wrt: c0_mem_wrt_i,
                    mem_addr: c0_mem_wrt_i ? c0_mem_addr_i : '0,
                    mem_data: c0_mem_wrt_i ? c0_mem_data_i : '0};
    assign rec1 = '{pc: c1_pc_i, instr: c1_instr_i, rd: c1_rd_i,
                    rd_data: c1_rd_i != 5'd0 ? c1_rd_data_i : '0, mem_wrt: c1_mem_wrt_i,
                    mem_addr: c1_mem_wrt_i ? c1_mem_addr_i : '0,
                    mem_data: c1_mem_wrt_i ? c1_mem_data_i : '0};
    assign in_ready_o = level_o <= READY_MAX;
    assign n_push     = in_ready_o ? {1'b0, c0_valid_i} + {1'b0, c1_valid_i} : 2'd0;
    assign update_o   = level_o != '0;
    assign pop        = update_o && trace_ready_i;
    assign head       = update_o ? fifo[rd_ptr] : '0;
    assign pc_o       = head.pc;
    assign instr_o    = head.instr;
    assign reg_addr_o = head.rd;
    assign reg_data_o = head.rd_data;
    assign mem_wrt_o  = head.mem_wrt;
    assign mem_addr_o = head.mem_addr;
    assign mem_data_o = head.mem_data;
    always_ff @(posedge clk_i) begin
        if (!rst_i && in_ready_o && c0_valid_i) fifo[wr_ptr] <= rec0;
        if (!rst_i && in_ready_o && c1_valid_i) fifo[wr_ptr + AW'(c0_valid_i)] <= rec1;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level_o       <= '0;
            overflow_o    <= 1'b0;
            retired_cnt_o <= '0;
        end else begin
            wr_ptr        <= wr_ptr + AW'(n_push);
            rd_ptr        <= rd_ptr + AW'(pop);
            level_o       <= level_o + (AW+1)'(n_push) - (AW+1)'(pop);
            overflow_o    <= overflow_o || ((c0_valid_i || c1_valid_i) && !in_ready_o);
            retired_cnt_o <= retired_cnt_o + 32'(pop);
        end
    end
endmodule

// File: tb/tb_commit_trace_serializer.sv
// tb_commit_trace_serializer: directed vector table plus backpressure, overflow, reset and wrap sequences.
module tb_commit_trace_serializer;
    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        c0_valid_i, c0_mem_wrt_i, c1_valid_i, c1_mem_wrt_i, trace_ready_i;
    logic [31:0] c0_pc_i, c0_instr_i, c0_rd_data_i, c0_mem_addr_i, c0_mem_data_i;
    logic [31:0] c1_pc_i, c1_instr_i, c1_rd_data_i, c1_mem_addr_i, c1_mem_data_i;
    logic [4:0]  c0_rd_i, c1_rd_i, reg_addr_o;
    logic        in_ready_o, update_o, mem_wrt_o, overflow_o;
    logic [31:0] pc_o, instr_o, reg_data_o, mem_addr_o, mem_data_o, retired_cnt_o;
    logic [3:0]  level_o;
    int n_cmp = 0, n_bad = 0;

    commit_trace_serializer #(.XLEN(32), .DEPTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .c0_valid_i(c0_valid_i), .c0_pc_i(c0_pc_i), .c0_instr_i(c0_instr_i), .c0_rd_i(c0_rd_i),
        .c0_rd_data_i(c0_rd_data_i), .c0_mem_wrt_i(c0_mem_wrt_i), .c0_mem_addr_i(c0_mem_addr_i),
        .c0_mem_data_i(c0_mem_data_i),
        .c1_valid_i(c1_valid_i), .c1_pc_i(c1_pc_i), .c1_instr_i(c1_instr_i), .c1_rd_i(c1_rd_i),
        .c1_rd_data_i(c1_rd_data_i), .c1_mem_wrt_i(c1_mem_wrt_i), .c1_mem_addr_i(c1_mem_addr_i),
        .c1_mem_data_i(c1_mem_data_i),
        .in_ready_o(in_ready_o), .trace_ready_i(trace_ready_i), .update_o(update_o),
        .pc_o(pc_o), .instr_o(instr_o), .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o),
        .mem_wrt_o(mem_wrt_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .level_o(level_o), .overflow_o(overflow_o), .retired_cnt_o(retired_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic c0v; logic [31:0] c0pc, c0in; logic [4:0] c0rd; logic [31:0] c0d; logic c0mw; logic [31:0] c0ma, c0md;
        logic c1v; logic [31:0] c1pc, c1in; logic [4:0] c1rd; logic [31:0] c1d; logic c1mw; logic [31:0] c1ma, c1md;
        logic trdy;
        logic eu; logic [31:0] epc, ein; logic [4:0] erd; logic [31:0] ed; logic emw; logic [31:0] ema, emd;
        logic [3:0] elv; logic [31:0] ecnt; logic eir;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        c0_valid_i = 0; c0_pc_i = 0; c0_instr_i = 0; c0_rd_i = 0; c0_rd_data_i = 0;
        c0_mem_wrt_i = 0; c0_mem_addr_i = 0; c0_mem_data_i = 0;
        c1_valid_i = 0; c1_pc_i = 0; c1_instr_i = 0; c1_rd_i = 0; c1_rd_data_i = 0;
        c1_mem_wrt_i = 0; c1_mem_addr_i = 0; c1_mem_data_i = 0;
    endtask

    task automatic push1(input logic [31:0] pc);
        idle();
        c0_valid_i = 1; c0_pc_i = pc; c0_instr_i = pc ^ 32'h13; c0_rd_i = 5'd2; c0_rd_data_i = pc + 1;
    endtask

    task automatic push2(input logic [31:0] pc);
        push1(pc);
        c1_valid_i = 1; c1_pc_i = pc + 4; c1_instr_i = (pc + 4) ^ 32'h13; c1_rd_i = 5'd2; c1_rd_data_i = pc + 5;
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        vecs[0] = '{1, 32'h80000000, 32'h00500093, 1, 5, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, 1,
                    1, 32'h80000000, 32'h00500093, 1, 5, 0, 0, 0, 1, 0, 1};
        vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vecs[2] = '{1, 32'h104, 32'h13, 0, 32'hDEADBEEF, 0, 32'h55, 32'h66,
                    1, 32'h108, 32'h00b12023, 0, 0, 1, 32'h100, 32'hAB, 0,
                    1, 32'h104, 32'h13, 0, 0, 0, 0, 0, 2, 1, 1};
        vecs[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                    1, 32'h108, 32'h00b12023, 0, 0, 1, 32'h100, 32'hAB, 1, 2, 1};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                    0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1};
        vecs[5] = '{0, 0, 0, 0, 0, 0, 0, 0,
                    1, 32'h200, 32'h00700193, 3, 7, 0, 0, 0, 0,
                    1, 32'h200, 32'h00700193, 3, 7, 0, 0, 0, 1, 3, 1};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                    0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1};

        idle();
        trace_ready_i = 0;
        c0_valid_i = 1; c0_pc_i = 32'h999;
        #3;
        chk("rst_update", 32'(update_o), 0);
        chk("rst_level", 32'(level_o), 0);
        chk("rst_in_ready", 32'(in_ready_o), 1);
        chk("rst_cnt", retired_cnt_o, 0);
        tick();
        tick();
        chk("rst_discard_level", 32'(level_o), 0);
        idle();
        rst_i = 0;
        tick();

        foreach (vecs[i]) begin
            c0_valid_i = vecs[i].c0v; c0_pc_i = vecs[i].c0pc; c0_instr_i = vecs[i].c0in; c0_rd_i = vecs[i].c0rd;
            c0_rd_data_i = vecs[i].c0d; c0_mem_wrt_i = vecs[i].c0mw; c0_mem_addr_i = vecs[i].c0ma; c0_mem_data_i = vecs[i].c0md;
            c1_valid_i = vecs[i].c1v; c1_pc_i = vecs[i].c1pc; c1_instr_i = vecs[i].c1in; c1_rd_i = vecs[i].c1rd;
            c1_rd_data_i = vecs[i].c1d; c1_mem_wrt_i = vecs[i].c1mw; c1_mem_addr_i = vecs[i].c1ma; c1_mem_data_i = vecs[i].c1md;
            trace_ready_i = vecs[i].trdy;
            tick();
            chk($sformatf("v%0d_update", i), 32'(update_o), 32'(vecs[i].eu));
            chk($sformatf("v%0d_pc", i), pc_o, vecs[i].epc);
            chk($sformatf("v%0d_instr", i), instr_o, vecs[i].ein);
            chk($sformatf("v%0d_rd", i), 32'(reg_addr_o), 32'(vecs[i].erd));
            chk($sformatf("v%0d_rd_data", i), reg_data_o, vecs[i].ed);
            chk($sformatf("v%0d_mem_wrt", i), 32'(mem_wrt_o), 32'(vecs[i].emw));
            chk($sformatf("v%0d_mem_addr", i), mem_addr_o, vecs[i].ema);
            chk($sformatf("v%0d_mem_data", i), mem_data_o, vecs[i].emd);
            chk($sformatf("v%0d_level", i), 32'(level_o), 32'(vecs[i].elv));
            chk($sformatf("v%0d_cnt", i), retired_cnt_o, vecs[i].ecnt);
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready_o), 32'(vecs[i].eir));
        end
        chk("no_overflow_yet", 32'(overflow_o), 0);

        // Backpressure: four dual pushes fill eight entries while the head holds.
        trace_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            push2(32'h1000 + 32'(8 * i));
            tick();
            chk($sformatf("bp%0d_level", i), 32'(level_o), 32'(2 * (i + 1)));
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready_o), i < 3 ? 1 : 0);
            chk($sformatf("bp%0d_head_pc", i), pc_o, 32'h1000);
            chk($sformatf("bp%0d_head_data", i), reg_data_o, 32'h1001);
        end
        push2(32'h5000);
        tick();
        chk("ovf_set", 32'(overflow_o), 1);
        chk("ovf_level", 32'(level_o), 8);
        idle();
        tick();
        chk("ovf_sticky", 32'(overflow_o), 1);
        trace_ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_pc", i), pc_o, 32'h1000 + 32'(4 * i));
            chk($sformatf("drain%0d_instr", i), instr_o, (32'h1000 + 32'(4 * i)) ^ 32'h13);
            tick();
        end
        chk("drain_level", 32'(level_o), 0);
        chk("drain_cnt", retired_cnt_o, 12);
        chk("drain_ovf_sticky", 32'(overflow_o), 1);

        // Reset mid-cycle with five buffered records.
        trace_ready_i = 0;
        for (int i = 0; i < 5; i++) begin
            push1(32'h300 + 32'(4 * i));
            tick();
        end
        idle();
        chk("pre_rst_level", 32'(level_o), 5);
        #2 rst_i = 1;
        #1;
        chk("mid_rst_update", 32'(update_o), 0);
        chk("mid_rst_level", 32'(level_o), 0);
        chk("mid_rst_pc", pc_o, 0);
        chk("mid_rst_ovf", 32'(overflow_o), 0);
        chk("mid_rst_cnt", retired_cnt_o, 0);
        chk("mid_rst_in_ready", 32'(in_ready_o), 1);
        @(negedge clk_i);
        push1(32'h777);
        tick();
        rst_i = 0;
        push1(32'h200);
        tick();
        idle();
        chk("post_rst_level", 32'(level_o), 1);
        chk("post_rst_pc", pc_o, 32'h200);

        // Wrap: 20 single commits under random consumer stalls.
        rst_i = 1;
        tick();
        rst_i = 0;
        begin
            int sent = 0, got = 0, bad_order = 0;
            for (int cyc = 0; cyc < 2000 && got < 20; cyc++) begin
                if (update_o !== (sent > got) || (update_o && pc_o !== 32'h4000 + 32'(4 * got)))
                    bad_order++;
                trace_ready_i = 1'($urandom_range(0, 1));
                if (update_o && trace_ready_i) got++;
                if (sent < 20 && in_ready_o) begin
                    push1(32'h4000 + 32'(4 * sent));
                    sent++;
                end else idle();
                tick();
            end
            idle();
            chk("wrap_order_errors", 32'(bad_order), 0);
            chk("wrap_records", 32'(got), 20);
            chk("wrap_cnt", retired_cnt_o, 20);
            chk("wrap_level", 32'(level_o), 0);
            chk("wrap_no_ovf", 32'(overflow_o), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
